// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  function automatic logic md_is_div(md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath.
// Multiply: acc = {partial, multiplier}; conditional add then shift right.
// Divide:   acc = {remainder, quotient}; shift left then restoring trial subtract.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // single add-shift or shift-subtract step
  always_comb begin
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    shifted = acc_in[2*WIDTH-1:WIDTH-1];
    trial   = shifted - {1'b0, opnd};
    acc_out = acc_in;
    if (div) begin
      // the remainder stays below the divisor, so bit WIDTH of trial is the borrow
      if (!trial[WIDTH]) acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      else               acc_out = {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
    end else if (acc_in[0]) begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end else begin
      acc_out = {1'b0, acc_in[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_controller.sv
// Sequencer for the 32-cycle multiply/divide unit: owns HI/LO, sign handling
// and the stall request to the hazard unit.
//   state   | meaning
//   MD_IDLE | waiting for StartE; Hi/Lo hold last result
//   MD_RUN  | one datapath iteration per edge; writes Hi/Lo at count WIDTH-1
module muldiv_controller
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic [1:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             ReadHiLoD,
  output logic             Busy,
  output logic             MdStall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  md_state_e          state, state_nxt;
  logic [CNT_W-1:0]   count;
  md_op_e             op_q, op_in;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic               neg_res, neg_rem, div_zero;
  logic [WIDTH-1:0]   srca_raw;
  logic               accept, last;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, hi_fix, lo_fix;

  assign op_in  = md_op_e'(OpE);
  assign accept = (state == MD_IDLE) && StartE;
  assign last   = (state == MD_RUN) && (count == CNT_W'(WIDTH - 1));
  assign a_neg  = md_is_signed(op_in) && SrcAE[WIDTH-1];
  assign b_neg  = md_is_signed(op_in) && SrcBE[WIDTH-1];
  assign mag_a  = a_neg ? -SrcAE : SrcAE;
  assign mag_b  = b_neg ? -SrcBE : SrcBE;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div     (md_is_div(op_q)),
    .acc_in  (acc),
    .opnd    (opnd),
    .acc_out (acc_nxt)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (StartE) state_nxt = MD_RUN;
      MD_RUN:  if (last)   state_nxt = MD_IDLE;
      default:             state_nxt = MD_IDLE;
    endcase
  end

  // FSM outputs: busy flag and stall request
  always_comb begin
    Busy    = (state == MD_RUN);
    MdStall = Busy && (StartE || ReadHiLoD);
  end

  // operand capture and iteration datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      op_q     <= MD_MULT;
      acc      <= '0;
      opnd     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      srca_raw <= '0;
    end else if (accept) begin
      count    <= '0;
      op_q     <= op_in;
      acc      <= {{WIDTH{1'b0}}, mag_a};
      opnd     <= mag_b;
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= md_is_div(op_in) && (SrcBE == '0);
      srca_raw <= SrcAE;
    end else if (state == MD_RUN) begin
      count <= count + CNT_W'(1);
      acc   <= acc_nxt;
    end
  end

  // sign fix-up of the final iteration's result
  always_comb begin
    prod   = neg_res ? -acc_nxt : acc_nxt;
    quo    = acc_nxt[WIDTH-1:0];
    rem    = acc_nxt[2*WIDTH-1:WIDTH];
    hi_fix = prod[2*WIDTH-1:WIDTH];
    lo_fix = prod[WIDTH-1:0];
    if (md_is_div(op_q)) begin
      if (div_zero) begin
        hi_fix = srca_raw;
        lo_fix = '1;
      end else begin
        hi_fix = neg_rem ? -rem : rem;
        lo_fix = neg_res ? -quo : quo;
      end
    end
  end

  // HI/LO write and completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Hi   <= '0;
      Lo   <= '0;
      Done <= 1'b0;
    end else begin
      Done <= last;
      if (last) begin
        Hi <= hi_fix;
        Lo <= lo_fix;
      end
    end
  end

endmodule
